spi_slave_regs: RTL and testbench
=================================

# spi_slave_regs

SPI responder with a 64 × 8 register file, the peer of the team's `spi_master`. It lets a second FPGA, or the same board looped back over GPIO, act as an MFRC522-style register target for bring-up of the RFID transfer path. All SPI pins are sampled in the `CLOCK_50` domain; no logic is clocked by `spi_clk`. A local port lets FPGA logic preload and inspect registers, and drives LEDs.

## Interface
- `SYNC_STAGES`, default 2: flip-flops in each pin synchronizer (`spi_clk`, `ss`, `mosi`); minimum 2.
- `AUTO_INC`, default 0: 1 = write address increments after each data byte (wraps 63→0); 0 = every data byte goes to the same address.
- `CLOCK_50` in 1: system clock, the only clock.
- `reset` in 1: asynchronous, active-low reset.
- `spi_clk` in 1: SPI clock from the master, mode 0 (idle low).
- `ss` in 1: slave select, active low.
- `mosi` in 1: master-out data, MSB first.
- `miso` out 1: slave-out data; driven 0 when idle (no tri-state).
- `busy` out 1: high while the synchronized `ss` is low.
- `wr_valid` out 1: one-cycle pulse when an SPI write commits.
- `wr_addr` out 6: address of the last SPI write.
- `wr_data` out 8: data of the last SPI write.
- `frame_err` out 1: one-cycle pulse when `ss` rises with a partial byte pending.
- `lcl_we` in 1: local write enable.
- `lcl_addr` in 6: local read/write address.
- `lcl_wdata` in 8: local write data.
- `lcl_rdata` out 8: registered value of `regs[lcl_addr]`.

## Operation
- **Address byte format:** bit7 = 1 means read, 0 means write; bits6:1 = register address; bit0 is ignored.
- **Edge detection:** edges are detected on synchronized signals only.
  - `sclk_rise`/`sclk_fall` come from `spi_clk` sync stage N vs N-1.
  - `ss_fall`/`ss_rise` come from `ss` the same way.
- **FSM: IDLE, ADDR, READ, WRITE.**
- **IDLE:** on `ss_fall`, clear `bit_cnt` (3 bits) and `rx_shift`, set `tx_shift` = 0x00, go to ADDR.
- **Every `sclk_rise` (any non-IDLE state):** `rx_shift` ← {`rx_shift[6:0]`, `mosi_sync`}; `bit_cnt`++.
- **Every `sclk_fall`:** `tx_shift` ← {`tx_shift[6:0]`, 0}.
- **`miso`:** always equals `tx_shift[7]`, registered.
- **Byte completion:** occurs on the `sclk_rise` where `bit_cnt` = 7; call the full byte B.
  - **ADDR, B[7]=1:** `addr` ← B[6:1]; `tx_shift` ← `regs[B[6:1]]`; go to READ.
  - **ADDR, B[7]=0:** `addr` ← B[6:1]; `tx_shift` ← 0x00; go to WRITE.
  - **READ, B[7]=1:** `tx_shift` ← `regs[B[6:1]]`, which makes it the next read address (pipelined MFRC522 style).
  - **READ, B[7]=0 (e.g. the 0x00 terminator):** `tx_shift` ← 0x00.
  - **WRITE:** `regs[addr]` ← B; `wr_valid` = 1, `wr_addr` = `addr`, `wr_data` = B; if `AUTO_INC`, `addr`++ mod 64.
- **Tx load and shift:** a `tx_shift` load at byte completion is not shifted by the `sclk_fall` that follows; that fall is the first slot in which the loaded bit7 appears on `miso`. Implement with a `skip_shift` flag cleared by that fall.
- **`ss_rise` from any state:** go to IDLE; `tx_shift` ← 0.
  - If `bit_cnt` ≠ 0: pulse `frame_err`; discard the partial byte (no write).
- **Local write:** `lcl_we` writes `regs[lcl_addr]` on the clock edge.
- **Simultaneous writes:** if an SPI write commits in the same cycle as `lcl_we` to the same address, the SPI write wins. Different addresses both commit.
- **Local read:** `lcl_rdata` ← `regs[lcl_addr]` every cycle; it reflects writes from the previous cycle.
- **Reset (`reset` low, any time, including mid-frame):**
  - FSM → IDLE; all registers and sync flops → 0; `miso`, `busy`, `wr_valid`, `frame_err`, `wr_addr`, `wr_data`, `lcl_rdata` = 0.
  - A frame in progress at release is ignored until the next `ss_fall`.

## Timing
- **Edge latency:** pin edge → internal edge pulse is `SYNC_STAGES`+1 `CLOCK_50` cycles.
- **`spi_clk` limits:** frequency ≤ `CLOCK_50`/8; high and low time each ≥ 4 cycles.
- **`ss` setup/hold:** `ss` low ≥ 4 cycles before the first `spi_clk` rise; high ≥ 4 cycles after the last fall.
- **`miso` valid:** within `SYNC_STAGES`+2 cycles of the `spi_clk` pin falling edge, which is before the master's next rising edge.
- **Write strobe:** `wr_valid` is high for exactly 1 cycle, on the cycle after the completing `sclk_rise` pulse.
- **Read data:** returned in the byte slot immediately after the byte carrying its address.
- **Master clock settings:** the team's master at `spi_clk_div` 6250000 (8 Hz) is far inside limits; the bench also runs `CLOCK_50`/8.

## Test plan
- **SPI write:** frame 0x24, 0x26 (write reg 0x12) → `wr_valid` once with `wr_addr`=0x12, `wr_data`=0x26; `lcl_addr`=0x12 gives `lcl_rdata`=0x26; `miso` stays 0 for the whole frame.
- **Pipelined read:** preload reg 0x12=0x26, reg 0x05=0x9C via local port; frame 0xA4, 0x8A, 0x00 → `miso` bytes 0x00, 0x26, 0x9C.
- **Burst write:** `AUTO_INC`=1; frame 0x7E, 0x11, 0x22 → reg 0x3F=0x11, reg 0x00=0x22 (wrap); two `wr_valid` pulses. With `AUTO_INC`=0, reg 0x3F=0x22.
- **Aborted byte:** after 0x24, raise `ss` after 5 data bits → `frame_err` single pulse; reg 0x12 unchanged; no `wr_valid`; the next full frame works normally.
- **Write collision:** SPI write 0x26 to reg 0x12 committing in the same cycle as `lcl_we` 0x55 to reg 0x12 → reg 0x12=0x26. Repeat with local address 0x13 → reg 0x13=0x55.
- **Reset mid-frame:** assert `reset` mid-frame (bit 3 of the data byte) → all outputs 0 and regs cleared immediately; after release with `ss` still low, no write occurs; the next frame decodes correctly.

Source files
------------

// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 responder with a 64x8 register file, all pins sampled in the CLOCK_50 domain
module spi_slave_regs #(
  parameter int SYNC_STAGES = 2,
  parameter bit AUTO_INC = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       busy,
  output logic       wr_valid,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err,
  input  logic       lcl_we,
  input  logic [5:0] lcl_addr,
  input  logic [7:0] lcl_wdata,
  output logic [7:0] lcl_rdata
);
  typedef enum logic [1:0] {IDLE, ADDR, READ, WRITE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES:0] sclk_s_q, sclk_s_d, ss_s_q, ss_s_d;
  logic [SYNC_STAGES-1:0] mosi_s_q, mosi_s_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d, wr_data_q, wr_data_d, lcl_rdata_q, lcl_rdata_d;
  logic [5:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic skip_q, skip_d, miso_q, miso_d, busy_q, busy_d;
  logic wr_valid_q, wr_valid_d, frame_err_q, frame_err_d;
  logic [7:0] regs_q [64];
  logic [7:0] regs_d [64];
  logic sclk_rise, sclk_fall, ss_rise, ss_fall, done;
  logic [7:0] rx_byte;
  assign sclk_rise = sclk_s_q[SYNC_STAGES-1] & ~sclk_s_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_s_q[SYNC_STAGES-1] & sclk_s_q[SYNC_STAGES];
  assign ss_rise = ss_s_q[SYNC_STAGES-1] & ~ss_s_q[SYNC_STAGES];
  assign ss_fall = ~ss_s_q[SYNC_STAGES-1] & ss_s_q[SYNC_STAGES];
  assign rx_byte = {rx_q, mosi_s_q[SYNC_STAGES-1]};
  assign done = (state_q != IDLE) && sclk_rise && (bit_cnt_q == 3'd7);
  always_comb begin
    sclk_s_d = {sclk_s_q[SYNC_STAGES-1:0], spi_clk};
    ss_s_d = {ss_s_q[SYNC_STAGES-1:0], ss};
    mosi_s_d = {mosi_s_q[SYNC_STAGES-2:0], mosi};
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    skip_d = skip_q;
    addr_d = addr_q;
    wr_valid_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    frame_err_d = 1'b0;
    miso_d = tx_q[7];
    busy_d = ~ss_s_q[SYNC_STAGES-1];
    lcl_rdata_d = regs_q[lcl_addr];
    regs_d = regs_q;
    if (lcl_we) regs_d[lcl_addr] = lcl_wdata;
    if (ss_rise) begin
      state_d = IDLE;
      tx_d = 8'h00;
      skip_d = 1'b0;
      frame_err_d = bit_cnt_q != 3'd0;
      bit_cnt_d = 3'd0;
    end else if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d = ADDR;
        bit_cnt_d = 3'd0;
        rx_d = 7'd0;
        tx_d = 8'h00;
        skip_d = 1'b0;
      end
    end else begin
      if (sclk_rise) begin
        rx_d = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      // a byte-completion load holds through the next fall so its bit7 gets a full slot
      if (sclk_fall) begin
        tx_d = skip_q ? tx_q : {tx_q[6:0], 1'b0};
        skip_d = 1'b0;
      end
      if (done) begin
        skip_d = 1'b1;
        if (state_q == WRITE) begin
          regs_d[addr_q] = rx_byte;
          wr_valid_d = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_byte;
          if (AUTO_INC) addr_d = addr_q + 6'd1;
        end else begin
          tx_d = rx_byte[7] ? regs_q[rx_byte[6:1]] : 8'h00;
          if (state_q == ADDR) begin
            addr_d = rx_byte[6:1];
            state_d = rx_byte[7] ? READ : WRITE;
          end
        end
      end
    end
  end
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sclk_s_q <= '0;
      ss_s_q <= '0;
      mosi_s_q <= '0;
      bit_cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      skip_q <= 1'b0;
      addr_q <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      frame_err_q <= 1'b0;
      miso_q <= 1'b0;
      busy_q <= 1'b0;
      lcl_rdata_q <= '0;
      regs_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      sclk_s_q <= sclk_s_d;
      ss_s_q <= ss_s_d;
      mosi_s_q <= mosi_s_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      skip_q <= skip_d;
      addr_q <= addr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      frame_err_q <= frame_err_d;
      miso_q <= miso_d;
      busy_q <= busy_d;
      lcl_rdata_q <= lcl_rdata_d;
      regs_q <= regs_d;
    end
  end
  assign miso = miso_q;
  assign busy = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign frame_err = frame_err_q;
  assign lcl_rdata = lcl_rdata_q;
endmodule

// File: tb/tb_spi_slave_regs.sv
// tb_spi_slave_regs: drives two responders (AUTO_INC 0 and 1) with one SPI master and checks them against a frame-level model
module tb_spi_slave_regs;
  logic clk = 1'b0, rst_n = 1'b0, spi_clk = 1'b0, ss = 1'b1, mosi = 1'b0, lcl_we = 1'b0;
  logic [5:0] lcl_addr = 6'd0;
  logic [7:0] lcl_wdata = 8'd0;
  logic miso0, busy0, wv0, fe0, miso1, busy1, wv1, fe1;
  logic [5:0] wa0, wa1;
  logic [7:0] wd0, wd1, rd0, rd1;
  spi_slave_regs #(.SYNC_STAGES(2), .AUTO_INC(1'b0)) u0 (
    .CLOCK_50(clk), .reset(rst_n), .spi_clk(spi_clk), .ss(ss), .mosi(mosi), .miso(miso0),
    .busy(busy0), .wr_valid(wv0), .wr_addr(wa0), .wr_data(wd0), .frame_err(fe0),
    .lcl_we(lcl_we), .lcl_addr(lcl_addr), .lcl_wdata(lcl_wdata), .lcl_rdata(rd0));
  spi_slave_regs #(.SYNC_STAGES(2), .AUTO_INC(1'b1)) u1 (
    .CLOCK_50(clk), .reset(rst_n), .spi_clk(spi_clk), .ss(ss), .mosi(mosi), .miso(miso1),
    .busy(busy1), .wr_valid(wv1), .wr_addr(wa1), .wr_data(wd1), .frame_err(fe1),
    .lcl_we(lcl_we), .lcl_addr(lcl_addr), .lcl_wdata(lcl_wdata), .lcl_rdata(rd1));
  always #10 clk = ~clk;
  int checks = 0, failures = 0;
  int wv0_n = 0, wv1_n = 0, fe0_n = 0, fe1_n = 0, mhi0_n = 0, mhi1_n = 0;
  always @(posedge clk) begin
    if (wv0) wv0_n <= wv0_n + 1;
    if (wv1) wv1_n <= wv1_n + 1;
    if (fe0) fe0_n <= fe0_n + 1;
    if (fe1) fe1_n <= fe1_n + 1;
    if (miso0) mhi0_n <= mhi0_n + 1;
    if (miso1) mhi1_n <= mhi1_n + 1;
  end
  logic [7:0] m0 [64];
  logic [7:0] m1 [64];
  logic [7:0] frm [$];
  logic [7:0] got0 [$];
  logic [7:0] got1 [$];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int exp_wv;
  logic [5:0] last0, last1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_outputs_zero(input string tag);
    chk({tag, " miso0"}, miso0, 0); chk({tag, " busy0"}, busy0, 0); chk({tag, " wv0"}, wv0, 0);
    chk({tag, " fe0"}, fe0, 0); chk({tag, " wa0"}, wa0, 0); chk({tag, " wd0"}, wd0, 0);
    chk({tag, " rd0"}, rd0, 0); chk({tag, " miso1"}, miso1, 0); chk({tag, " busy1"}, busy1, 0);
    chk({tag, " wv1"}, wv1, 0); chk({tag, " fe1"}, fe1, 0); chk({tag, " wa1"}, wa1, 0);
    chk({tag, " wd1"}, wd1, 0); chk({tag, " rd1"}, rd1, 0);
  endtask
  task automatic lwrite(input logic [5:0] a, input logic [7:0] d);
    lcl_addr = a; lcl_wdata = d; lcl_we = 1'b1;
    tick(1);
    lcl_we = 1'b0;
    m0[a] = d; m1[a] = d;
  endtask
  task automatic check_regs(input string tag);
    for (int a = 0; a < 64; a++) begin
      lcl_addr = 6'(a);
      tick(2);
      chk($sformatf("%s reg0[%0h]", tag, a), rd0, m0[a]);
      chk($sformatf("%s reg1[%0h]", tag, a), rd1, m1[a]);
    end
  endtask
  task automatic model_frame(input int nfull);
    logic [7:0] p;
    logic [5:0] a0, a1;
    exp0.delete(); exp1.delete(); exp_wv = 0;
    p = frm[0];
    if (p[7]) begin
      for (int i = 0; i < nfull; i++) begin
        if (i == 0) begin
          exp0.push_back(8'h00); exp1.push_back(8'h00);
        end else begin
          p = frm[i-1];
          exp0.push_back(p[7] ? m0[p[6:1]] : 8'h00);
          exp1.push_back(p[7] ? m1[p[6:1]] : 8'h00);
        end
      end
    end else begin
      a0 = p[6:1]; a1 = p[6:1];
      for (int i = 0; i < nfull; i++) begin
        exp0.push_back(8'h00); exp1.push_back(8'h00);
      end
      for (int i = 1; i < nfull; i++) begin
        m0[a0] = frm[i]; m1[a1] = frm[i];
        last0 = a0; last1 = a1;
        a1 = a1 + 6'd1;
      end
      exp_wv = nfull - 1;
    end
  endtask
  task automatic spi_frame(input int pbits, input bit coll, input logic [5:0] caddr, input bit rst_mid);
    logic [7:0] b0, b1, p;
    int n, bits;
    got0.delete(); got1.delete();
    n = frm.size();
    ss = 1'b0;
    tick(5);
    chk("busy0 in frame", busy0, 1);
    for (int i = 0; i < n; i++) begin
      bits = (i == n - 1 && pbits > 0) ? pbits : 8;
      p = frm[i];
      b0 = 8'h00; b1 = 8'h00;
      for (int k = 0; k < bits; k++) begin
        mosi = p[7-k];
        if (rst_mid && i == 1 && k == 3) begin
          rst_n = 1'b0;
          tick(1);
          chk_outputs_zero("mid-frame reset");
          for (int a = 0; a < 64; a++) begin
            m0[a] = 8'h00; m1[a] = 8'h00;
          end
          rst_n = 1'b1;
        end
        tick(4);
        b0 = {b0[6:0], miso0}; b1 = {b1[6:0], miso1};
        spi_clk = 1'b1;
        if (coll && i == 1 && k == 7) begin
          // the SPI commit lands SYNC_STAGES+1 edges after the pin rise; hit exactly that edge
          tick(2);
          lcl_addr = caddr; lcl_wdata = 8'h55; lcl_we = 1'b1;
          tick(1);
          lcl_we = 1'b0;
          tick(1);
        end else tick(4);
        spi_clk = 1'b0;
      end
      if (bits == 8) begin
        got0.push_back(b0); got1.push_back(b1);
      end
    end
    tick(5);
    ss = 1'b1;
    tick(8);
    chk("busy0 after frame", busy0, 0);
  endtask
  task automatic do_frame(input string tag, input int pbits, input bit coll, input logic [5:0] caddr);
    int s_wv0, s_wv1, s_fe0, s_fe1, s_m0, s_m1, nfull;
    logic [7:0] p;
    nfull = frm.size() - (pbits > 0 ? 1 : 0);
    s_wv0 = wv0_n; s_wv1 = wv1_n; s_fe0 = fe0_n; s_fe1 = fe1_n; s_m0 = mhi0_n; s_m1 = mhi1_n;
    model_frame(nfull);
    spi_frame(pbits, coll, caddr, 1'b0);
    for (int i = 0; i < nfull; i++) begin
      chk($sformatf("%s miso0 byte%0d", tag, i), got0[i], exp0[i]);
      chk($sformatf("%s miso1 byte%0d", tag, i), got1[i], exp1[i]);
    end
    chk({tag, " wr_valid0 count"}, wv0_n - s_wv0, exp_wv);
    chk({tag, " wr_valid1 count"}, wv1_n - s_wv1, exp_wv);
    chk({tag, " frame_err0 count"}, fe0_n - s_fe0, pbits > 0 ? 1 : 0);
    chk({tag, " frame_err1 count"}, fe1_n - s_fe1, pbits > 0 ? 1 : 0);
    p = frm[0];
    if (!p[7]) begin
      chk({tag, " miso0 quiet"}, mhi0_n - s_m0, 0);
      chk({tag, " miso1 quiet"}, mhi1_n - s_m1, 0);
      if (exp_wv > 0) begin
        chk({tag, " wr_addr0"}, wa0, last0); chk({tag, " wr_data0"}, wd0, frm[nfull-1]);
        chk({tag, " wr_addr1"}, wa1, last1); chk({tag, " wr_data1"}, wd1, frm[nfull-1]);
      end
    end
  endtask
  initial begin
    int s_wv0, s_fe0;
    logic [5:0] ra;
    for (int a = 0; a < 64; a++) begin
      m0[a] = 8'h00; m1[a] = 8'h00;
    end
    tick(3);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick(5);
    frm = '{8'h24, 8'h26};
    do_frame("spi write", 0, 1'b0, 6'd0);
    lcl_addr = 6'h12; tick(2);
    chk("spi write lcl_rdata", rd0, 8'h26);
    lwrite(6'h12, 8'h26);
    lwrite(6'h05, 8'h9C);
    frm = '{8'hA4, 8'h8A, 8'h00};
    do_frame("pipelined read", 0, 1'b0, 6'd0);
    chk("pipelined read slot2 dut0", got0[2], 8'h9C);
    frm = '{8'h7E, 8'h11, 8'h22};
    do_frame("burst write", 0, 1'b0, 6'd0);
    lcl_addr = 6'h3F; tick(2);
    chk("burst noinc reg3F", rd0, 8'h22); chk("burst inc reg3F", rd1, 8'h11);
    lcl_addr = 6'h00; tick(2);
    chk("burst inc wrap reg00", rd1, 8'h22);
    frm = '{8'h24, 8'hB5};
    do_frame("aborted byte", 5, 1'b0, 6'd0);
    frm = '{8'h24, 8'h5A};
    do_frame("after abort", 0, 1'b0, 6'd0);
    check_regs("after abort");
    frm = '{8'h24, 8'h26};
    do_frame("collision same", 0, 1'b1, 6'h12);
    frm = '{8'h24, 8'h26};
    do_frame("collision diff", 0, 1'b1, 6'h13);
    m0[6'h13] = 8'h55; m1[6'h13] = 8'h55;
    check_regs("collision");
    s_wv0 = wv0_n; s_fe0 = fe0_n;
    frm = '{8'h24, 8'h77};
    spi_frame(0, 1'b0, 6'd0, 1'b1);
    chk("reset frame wr_valid count", wv0_n - s_wv0, 0);
    chk("reset frame frame_err count", fe0_n - s_fe0, 0);
    check_regs("after reset");
    frm = '{8'h24, 8'h26};
    do_frame("post-reset write", 0, 1'b0, 6'd0);
    frm = '{8'hA4, 8'h00};
    do_frame("post-reset read", 0, 1'b0, 6'd0);
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 2) == 0) lwrite(6'($urandom_range(0, 63)), 8'($urandom));
      frm.delete();
      ra = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        frm.push_back({1'b1, ra, 1'($urandom)});
        for (int j = $urandom_range(0, 2); j > 0; j--) frm.push_back({1'b1, 6'($urandom), 1'($urandom)});
        frm.push_back(8'h00);
      end else begin
        frm.push_back({1'b0, ra, 1'($urandom)});
        for (int j = $urandom_range(1, 3); j > 0; j--) frm.push_back(8'($urandom));
      end
      do_frame($sformatf("random%0d", r), 0, 1'b0, 6'd0);
    end
    check_regs("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
